dec_seq: RTL and testbench



---
 rtl/dec_pkg.sv | 23 ++
 rtl/dec_seq_if.sv | 29 ++
 rtl/dec_onehot.sv | 18 +
 rtl/dec_seq.sv | 120 ++++++++++++
 tb/tb_dec_seq.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/dec_pkg.sv
// Shared types for the sequenced one-hot decoder: command modes and FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package dec_pkg;

  localparam int MODE_W = 2;

  // Command carried on the mode input, sampled only with load.
  typedef enum logic [MODE_W-1:0] {
    MODE_OFF    = 2'd0,
    MODE_DIRECT = 2'd1,
    MODE_SCAN   = 2'd2,
    MODE_PULSE  = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HOLD  = 2'd1,
    ST_SCAN  = 2'd2,
    ST_PULSE = 2'd3
  } state_e;

endpackage

// File: rtl/dec_seq_if.sv
// Command/status bundle between a controller (master) and dec_seq (slave).
// Latency: n/a (wires only).
// Backpressure: none; load is a one-cycle strobe, en gates sequencing.
// Signals: load/mode/sel/dwell/en from master; out/busy/wrap/done from slave.
interface dec_seq_if #(
  parameter int SEL_W   = 3,
  parameter int OUT_W   = 2**SEL_W,
  parameter int DWELL_W = 8
);
  logic                       load;
  logic [dec_pkg::MODE_W-1:0] mode;
  logic [SEL_W-1:0]           sel;
  logic [DWELL_W-1:0]         dwell;
  logic                       en;
  logic [OUT_W-1:0]           out;
  logic                       busy;
  logic                       wrap;
  logic                       done;

  modport master (
    output load, mode, sel, dwell, en,
    input  out, busy, wrap, done
  );

  modport slave (
    input  load, mode, sel, dwell, en,
    output out, busy, wrap, done
  );
endinterface

// File: rtl/dec_onehot.sv
// Combinational binary-to-one-hot decoder, 2**SEL_W outputs.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
// Ports: sel (binary index in), onehot (exactly one bit set out).
module dec_onehot #(
  parameter int SEL_W = 3,
  parameter int OUT_W = 2**SEL_W
) (
  input  logic [SEL_W-1:0] sel,
  output logic [OUT_W-1:0] onehot
);

  always_comb begin
    onehot      = '0;
    onehot[sel] = 1'b1;
  end

endmodule

// File: rtl/dec_seq.sv
// Registered one-hot decoder with held, auto-scan and timed one-shot modes.
// Latency: load sampled at an edge drives out/busy from that same edge (1 cycle).
// Backpressure: en=0 freezes the dwell counter and index; load always restarts.
// Ports: clk, rst (sync, active-high), bus (dec_seq_if.slave: command in, out/busy/wrap/done).
module dec_seq
  import dec_pkg::*;
#(
  parameter int SEL_W   = 3,
  parameter int OUT_W   = 2**SEL_W,
  parameter int DWELL_W = 8
) (
  input  logic      clk,
  input  logic      rst,
  dec_seq_if.slave  bus
);

  state_e             state;
  logic [SEL_W-1:0]   idx;
  logic [DWELL_W-1:0] cnt;
  logic [DWELL_W-1:0] dwell_q;
  logic [OUT_W-1:0]   out_q;
  logic               busy_q;
  logic               wrap_q;
  logic               done_q;

  logic [SEL_W-1:0]   idx_inc;
  logic [SEL_W-1:0]   dec_in;
  logic [OUT_W-1:0]   dec_oh;

  // Index increment wraps naturally at SEL_W bits, which is mod OUT_W.
  assign idx_inc = idx + 1'b1;

  // One decoder serves both cases: a load decodes the new sel, otherwise
  // the only place out changes to a non-zero value is a SCAN advance.
  assign dec_in = bus.load ? bus.sel : idx_inc;

  dec_onehot #(
    .SEL_W (SEL_W),
    .OUT_W (OUT_W)
  ) u_onehot (
    .sel    (dec_in),
    .onehot (dec_oh)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      idx     <= '0;
      cnt     <= '0;
      dwell_q <= '0;
      out_q   <= '0;
      busy_q  <= 1'b0;
      wrap_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      wrap_q <= 1'b0;
      done_q <= 1'b0;
      if (bus.load) begin
        // Load preempts any pending expiry, so no wrap/done can leak out.
        case (mode_e'(bus.mode))
          MODE_DIRECT: begin
            state  <= ST_HOLD;
            out_q  <= dec_oh;
            busy_q <= 1'b0;
          end
          MODE_SCAN: begin
            state   <= ST_SCAN;
            idx     <= bus.sel;
            cnt     <= bus.dwell;
            dwell_q <= bus.dwell;
            out_q   <= dec_oh;
            busy_q  <= 1'b1;
          end
          MODE_PULSE: begin
            state   <= ST_PULSE;
            cnt     <= bus.dwell;
            dwell_q <= bus.dwell;
            out_q   <= dec_oh;
            busy_q  <= 1'b1;
          end
          default: begin
            state  <= ST_IDLE;
            out_q  <= '0;
            busy_q <= 1'b0;
          end
        endcase
      end else if (bus.en) begin
        case (state)
          ST_SCAN: begin
            if (cnt != '0) begin
              cnt <= cnt - 1'b1;
            end else begin
              idx    <= idx_inc;
              cnt    <= dwell_q;
              out_q  <= dec_oh;
              wrap_q <= (idx == '1);
            end
          end
          ST_PULSE: begin
            if (cnt != '0) begin
              cnt <= cnt - 1'b1;
            end else begin
              state  <= ST_IDLE;
              out_q  <= '0;
              busy_q <= 1'b0;
              done_q <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.out  = out_q;
  assign bus.busy = busy_q;
  assign bus.wrap = wrap_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_dec_seq.sv
module tb_dec_seq;

  logic clk;
  logic rst;

  dec_seq_if #(.SEL_W(3), .DWELL_W(8)) bus ();

  dec_seq #(.SEL_W(3), .DWELL_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nvec;
  int nerr;

  // Reference model: a mode plus a count of enabled cycles since the load.
  // Position in a scan is start + elapsed/(dwell+1); a pulse ends once
  // elapsed reaches dwell+1.
  int m_mode;
  int m_sel;
  int m_dw;
  int m_el;
  bit m_wrap;
  bit m_done;

  function automatic int m_idx();
    return (m_sel + m_el / (m_dw + 1)) % 8;
  endfunction

  function automatic logic [7:0] m_out();
    logic [7:0] one;
    one = 8'h01;
    case (m_mode)
      1, 3:    return one << m_sel;
      2:       return one << m_idx();
      default: return 8'h00;
    endcase
  endfunction

  task automatic model_step();
    m_wrap = 1'b0;
    m_done = 1'b0;
    if (rst) begin
      m_mode = 0;
    end else if (bus.load) begin
      m_mode = int'(bus.mode);
      m_sel  = int'(bus.sel);
      m_dw   = int'(bus.dwell);
      m_el   = 0;
    end else if (bus.en && m_mode == 2) begin
      m_el++;
      m_wrap = (m_el % (m_dw + 1) == 0) && (m_idx() == 0);
    end else if (bus.en && m_mode == 3) begin
      m_el++;
      if (m_el == m_dw + 1) begin
        m_mode = 0;
        m_done = 1'b1;
      end
    end
  endtask

  task automatic cyc(input logic r, input logic ld, input logic [1:0] md,
                     input logic [2:0] s, input logic [7:0] dw, input logic e);
    rst       = r;
    bus.load  = ld;
    bus.mode  = md;
    bus.sel   = s;
    bus.dwell = dw;
    bus.en    = e;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic chk(input string nm, input logic [7:0] eo, input logic eb,
                     input logic ew, input logic ed);
    nvec++;
    if ({bus.out, bus.busy, bus.wrap, bus.done} !== {eo, eb, ew, ed}) begin
      nerr++;
      $display("FAIL %s: got out=%h busy=%b wrap=%b done=%b, want out=%h busy=%b wrap=%b done=%b",
               nm, bus.out, bus.busy, bus.wrap, bus.done, eo, eb, ew, ed);
    end
  endtask

  typedef struct {
    logic       rst;
    logic       load;
    logic [1:0] mode;
    logic [2:0] sel;
    logic [7:0] dwell;
    logic       en;
    logic [7:0] out;
    logic       busy;
    logic       wrap;
    logic       done;
  } vec_t;

  vec_t tbl[18];

  function automatic vec_t mk(input logic r, input logic ld, input logic [1:0] md,
                              input logic [2:0] s, input logic [7:0] dw, input logic e,
                              input logic [7:0] eo, input logic eb, input logic ew,
                              input logic ed);
    vec_t v;
    v.rst = r;  v.load = ld; v.mode = md; v.sel = s; v.dwell = dw; v.en = e;
    v.out = eo; v.busy = eb; v.wrap = ew; v.done = ed;
    return v;
  endfunction

  initial begin
    nvec = 0;
    nerr = 0;
    m_mode = 0; m_sel = 0; m_dw = 0; m_el = 0; m_wrap = 1'b0; m_done = 1'b0;
    rst = 1'b1; bus.load = 1'b0; bus.mode = 2'd0; bus.sel = 3'd0;
    bus.dwell = 8'd0; bus.en = 1'b0;

    //              rst   load  mode  sel   dwell en      out    busy  wrap  done
    tbl[0]  = mk(1'b1, 1'b0, 2'd0, 3'd0, 8'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    tbl[1]  = mk(1'b1, 1'b1, 2'd2, 3'd3, 8'd0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
    tbl[2]  = mk(1'b0, 1'b1, 2'd1, 3'd5, 8'd0, 1'b0, 8'h20, 1'b0, 1'b0, 1'b0);
    tbl[3]  = mk(1'b0, 1'b0, 2'd2, 3'd1, 8'd0, 1'b1, 8'h20, 1'b0, 1'b0, 1'b0);
    tbl[4]  = mk(1'b0, 1'b0, 2'd3, 3'd7, 8'd4, 1'b1, 8'h20, 1'b0, 1'b0, 1'b0);
    tbl[5]  = mk(1'b0, 1'b1, 2'd3, 3'd2, 8'd3, 1'b1, 8'h04, 1'b1, 1'b0, 1'b0);
    tbl[6]  = mk(1'b0, 1'b0, 2'd0, 3'd0, 8'd0, 1'b1, 8'h04, 1'b1, 1'b0, 1'b0);
    tbl[7]  = mk(1'b0, 1'b0, 2'd0, 3'd0, 8'd0, 1'b1, 8'h04, 1'b1, 1'b0, 1'b0);
    tbl[8]  = mk(1'b0, 1'b0, 2'd0, 3'd0, 8'd0, 1'b1, 8'h04, 1'b1, 1'b0, 1'b0);
    tbl[9]  = mk(1'b0, 1'b0, 2'd0, 3'd0, 8'd0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1);
    tbl[10] = mk(1'b0, 1'b0, 2'd0, 3'd0, 8'd0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
    tbl[11] = mk(1'b0, 1'b1, 2'd3, 3'd7, 8'd0, 1'b1, 8'h80, 1'b1, 1'b0, 1'b0);
    tbl[12] = mk(1'b0, 1'b0, 2'd0, 3'd0, 8'd0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1);
    tbl[13] = mk(1'b0, 1'b1, 2'd2, 3'd0, 8'd0, 1'b1, 8'h01, 1'b1, 1'b0, 1'b0);
    tbl[14] = mk(1'b0, 1'b0, 2'd0, 3'd0, 8'd0, 1'b1, 8'h02, 1'b1, 1'b0, 1'b0);
    tbl[15] = mk(1'b0, 1'b1, 2'd0, 3'd6, 8'd0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
    tbl[16] = mk(1'b0, 1'b1, 2'd1, 3'd0, 8'd0, 1'b1, 8'h01, 1'b0, 1'b0, 1'b0);
    tbl[17] = mk(1'b0, 1'b0, 2'd3, 3'd4, 8'd0, 1'b0, 8'h01, 1'b0, 1'b0, 1'b0);

    foreach (tbl[i]) begin
      cyc(tbl[i].rst, tbl[i].load, tbl[i].mode, tbl[i].sel, tbl[i].dwell, tbl[i].en);
      chk($sformatf("tbl%0d", i), tbl[i].out, tbl[i].busy, tbl[i].wrap, tbl[i].done);
    end

    // DIRECT held for 20 cycles with mode/sel toggling but no load.
    cyc(1'b0, 1'b1, 2'd1, 3'd5, 8'd0, 1'b1);
    for (int i = 0; i < 20; i++) begin
      cyc(1'b0, 1'b0, 2'(i % 4), 3'(i), 8'(i), 1'(i % 2));
      chk("direct_hold", 8'h20, 1'b0, 1'b0, 1'b0);
    end

    // SCAN wrap: sel=6 dwell=2.
    cyc(1'b0, 1'b1, 2'd2, 3'd6, 8'd2, 1'b1);
    chk("scan_first", 8'h40, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      cyc(1'b0, 1'b0, 2'd0, 3'd0, 8'd0, 1'b1);
      chk("scan_6", 8'h40, 1'b1, 1'b0, 1'b0);
    end
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0, 2'd0, 3'd0, 8'd0, 1'b1);
      chk("scan_7", 8'h80, 1'b1, 1'b0, 1'b0);
    end
    cyc(1'b0, 1'b0, 2'd0, 3'd0, 8'd0, 1'b1);
    chk("scan_wrap", 8'h01, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 2'd0, 3'd0, 8'd0, 1'b1);
    chk("scan_after_wrap", 8'h01, 1'b1, 1'b0, 1'b0);

    // SCAN pause: one dwell cycle of index 0 remains across the pause.
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 1'b0, 2'd0, 3'd0, 8'd0, 1'b0);
      chk("scan_pause", 8'h01, 1'b1, 1'b0, 1'b0);
    end
    cyc(1'b0, 1'b0, 2'd0, 3'd0, 8'd0, 1'b1);
    chk("scan_resume", 8'h01, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 2'd0, 3'd0, 8'd0, 1'b1);
    chk("scan_advance", 8'h02, 1'b1, 1'b0, 1'b0);

    // Reset mid-SCAN, with a competing load: reset wins.
    cyc(1'b1, 1'b1, 2'd1, 3'd3, 8'd0, 1'b1);
    chk("rst_mid_scan", 8'h00, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 2'd0, 3'd0, 8'd0, 1'b1);
    chk("rst_mid_scan2", 8'h00, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 2'd0, 3'd0, 8'd0, 1'b1);
    chk("after_rst", 8'h00, 1'b0, 1'b0, 1'b0);

    // Restart: long PULSE overridden by DIRECT at cycle 4, no done ever.
    cyc(1'b0, 1'b1, 2'd3, 3'd3, 8'd10, 1'b1);
    chk("restart_pulse", 8'h08, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0, 2'd0, 3'd0, 8'd0, 1'b1);
      chk("restart_pulse_run", 8'h08, 1'b1, 1'b0, 1'b0);
    end
    cyc(1'b0, 1'b1, 2'd1, 3'd0, 8'd0, 1'b1);
    chk("restart_direct", 8'h01, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) begin
      cyc(1'b0, 1'b0, 2'd0, 3'd0, 8'd0, 1'b1);
      chk("restart_no_done", 8'h01, 1'b0, 1'b0, 1'b0);
    end

    // Load coinciding with expiry suppresses done, then wrap.
    cyc(1'b0, 1'b1, 2'd3, 3'd1, 8'd1, 1'b1);
    chk("exp_pulse", 8'h02, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 2'd0, 3'd0, 8'd0, 1'b1);
    chk("exp_pulse2", 8'h02, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 2'd2, 3'd7, 8'd0, 1'b1);
    chk("exp_load_no_done", 8'h80, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 2'd0, 3'd0, 8'd0, 1'b1);
    chk("exp_wrap", 8'h01, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 2'd2, 3'd7, 8'd0, 1'b1);
    chk("exp_reload", 8'h80, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 2'd1, 3'd4, 8'd0, 1'b1);
    chk("exp_load_no_wrap", 8'h10, 1'b0, 1'b0, 1'b0);

    // PULSE stalled by en=0 keeps its full length.
    cyc(1'b0, 1'b1, 2'd3, 3'd6, 8'd1, 1'b0);
    chk("pstall_start", 8'h40, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0, 2'd0, 3'd0, 8'd0, 1'b0);
      chk("pstall_hold", 8'h40, 1'b1, 1'b0, 1'b0);
    end
    cyc(1'b0, 1'b0, 2'd0, 3'd0, 8'd0, 1'b1);
    chk("pstall_last", 8'h40, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 2'd0, 3'd0, 8'd0, 1'b1);
    chk("pstall_done", 8'h00, 1'b0, 1'b0, 1'b1);

    // Randomised traffic against the reference model.
    for (int i = 0; i < 3000; i++) begin
      logic       r;
      logic       ld;
      logic [7:0] dw;
      r  = ($urandom_range(0, 199) == 0);
      ld = ($urandom_range(0, 7) == 0);
      dw = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 20))
                                       : 8'($urandom_range(0, 2));
      cyc(r, ld, 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), dw,
          ($urandom_range(0, 3) != 0));
      chk("random", m_out(), (m_mode == 2 || m_mode == 3), m_wrap, m_done);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
